// File: rtl/lsu_align_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_align_unit                                                  |
// | Purpose  : Load/store alignment unit between the core memory stage and a   |
// |            word-wide data memory port. Builds byte enables and lane-placed |
// |            store data, extracts and extends load data, and sequences one   |
// |            or two bus beats through a req/ack handshake.                   |
// | Options  : define LSU_MISALIGN_SPLIT_EN to execute misaligned accesses     |
// |            (two beats when the access crosses a word boundary); without it |
// |            every misaligned access completes with rsp_fault and no beat.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lsu_align_unit #(
    parameter int XLEN = 32,
    parameter int NB   = XLEN / 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [NB-1:0]   mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    // Byte-offset width and a width wide enough to hold offset + size.
    localparam int c_OFFW   = $clog2(NB);
    localparam int c_SUMW   = c_OFFW + 2;
    localparam bit c_XLEN64 = (XLEN == 64);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BEAT0 = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] c_ST_BEAT1 = 2'd2;
`endif
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    // Mask the assembled bytes to the access size, then sign- or zero-extend.
    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] a,
                                                 input logic [2:0]      f3);
        logic [XLEN-1:0] mask;
        logic            sign;
        int              nbits;
        nbits = 8 << f3[1:0];
        mask  = (f3[1:0] == 2'b11) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        sign  = (|(a & (XLEN'(1) << (nbits - 1)))) & ~f3[2];
        return (a & mask) | (sign ? ~mask : '0);
    endfunction

    logic [1:0]        r_state;
    logic              r_store;
    logic [2:0]        r_f3;
    logic [c_OFFW-1:0] r_off;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_fault;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [XLEN-1:0]   r_mem_addr;
    logic [NB-1:0]     r_mem_be;
    logic [XLEN-1:0]   r_mem_wdata;

    logic [1:0]        w_szl;
    logic [c_OFFW-1:0] w_off;
    logic [c_SUMW-1:0] w_size;
    logic              w_legal;
    logic              w_fault;
    logic [NB-1:0]     w_be0;
    logic [XLEN-1:0]   w_rd0;
    logic [XLEN-1:0]   w_final;
    logic [XLEN-1:0]   w_ext;

    assign w_szl  = req_funct3[1:0];
    assign w_off  = req_addr[c_OFFW-1:0];
    assign w_size = c_SUMW'(1) << w_szl;

    // funct3 legality; doubleword forms exist only on a 64-bit datapath.
    always_comb begin
        w_legal = 1'b0;
        if (req_store) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                3'b011:                 w_legal = c_XLEN64;
                default:                w_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                3'b011, 3'b110:                         w_legal = c_XLEN64;
                default:                                w_legal = 1'b0;
            endcase
        end
    end

    // First-beat byte enables: size lanes starting at the byte offset, clipped to the word.
    always_comb begin
        w_be0 = '0;
        for (int i = 0; i < NB; i++) begin
            w_be0[i] = (i >= int'(w_off)) && (i < int'({2'b00, w_off} + w_size));
        end
    end

    // Beat-0 read bytes moved down to lane 0.
    assign w_rd0 = mem_rdata >> {r_off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              r_cross;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_asm;
    logic              w_cross;
    logic [c_SUMW-1:0] w_rsize;
    logic [c_SUMW-1:0] w_rsh;
    logic [NB-1:0]     w_be1;
    logic [XLEN-1:0]   w_wd1;
    logic [XLEN-1:0]   w_asm1;

    // Misaligned accesses are executed; only the word crossing matters.
    assign w_cross = ({2'b00, w_off} + w_size) > c_SUMW'(NB);
    assign w_fault = ~w_legal;

    // Second beat: remaining lanes from lane 0, store data continues where beat 0 stopped.
    assign w_rsize = c_SUMW'(1) << r_f3[1:0];
    assign w_rsh   = c_SUMW'(NB) - {2'b00, r_off};
    assign w_wd1   = r_wdata >> {w_rsh, 3'b000};
    assign w_asm1  = r_asm | (mem_rdata << {w_rsh, 3'b000});

    // Second-beat byte enables: the (off + size - NB) low lanes.
    always_comb begin
        w_be1 = '0;
        for (int i = 0; i < NB; i++) begin
            w_be1[i] = (i + NB) < int'({2'b00, r_off} + w_rsize);
        end
    end

    assign w_final = (r_state == c_ST_BEAT1) ? w_asm1 : w_rd0;
`else
    logic [c_OFFW-1:0] w_amask;
    logic              w_misal;

    // Without splitting, any address not a multiple of the size is rejected.
    assign w_amask = c_OFFW'(w_size - c_SUMW'(1));
    assign w_misal = |(w_off & w_amask);
    assign w_fault = ~w_legal | w_misal;
    assign w_final = w_rd0;
`endif

    assign w_ext = f_extend(w_final, r_f3);

    // Access sequencer: accept, run the bus beat(s), pulse the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_store     <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cross     <= 1'b0;
            r_wdata     <= '0;
            r_asm       <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_store     <= req_store;
                        r_f3        <= req_funct3;
                        r_off       <= w_off;
                        r_req_ready <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_cross     <= w_cross;
                        r_wdata     <= req_wdata;
`endif
                        if (w_fault) begin
                            r_state     <= c_ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_fault <= 1'b1;
                        end else begin
                            r_state     <= c_ST_BEAT0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_store;
                            r_mem_addr  <= {req_addr[XLEN-1:c_OFFW], {c_OFFW{1'b0}}};
                            r_mem_be    <= w_be0;
                            r_mem_wdata <= req_wdata << {w_off, 3'b000};
                        end
                    end
                end
                c_ST_BEAT0: begin
                    if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (r_cross) begin
                            r_asm       <= w_rd0;
                            r_state     <= c_ST_BEAT1;
                            r_mem_addr  <= r_mem_addr + XLEN'(NB);
                            r_mem_be    <= w_be1;
                            r_mem_wdata <= w_wd1;
                        end else begin
                            r_state     <= c_ST_RESP;
                            r_mem_req   <= 1'b0;
                            r_mem_we    <= 1'b0;
                            r_mem_be    <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= r_store ? '0 : w_ext;
                        end
`else
                        r_state     <= c_ST_RESP;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_store ? '0 : w_ext;
`endif
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                c_ST_BEAT1: begin
                    if (mem_ack) begin
                        r_state     <= c_ST_RESP;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_store ? '0 : w_ext;
                    end
                end
`endif
                c_ST_RESP: begin
                    r_state     <= c_ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lsu_align_unit                                               |
// | Purpose  : Directed self-checking bench for lsu_align_unit at XLEN=32 and  |
// |            XLEN=64, with a scripted memory responder per access.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_lsu_align_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wire        a_valid = req_valid & ~sel;
    wire        b_valid = req_valid & sel;
    wire        a_ack   = mem_ack & ~sel;
    wire        b_ack   = mem_ack & sel;

    wire        a_req_ready, a_rsp_valid, a_rsp_fault, a_mem_req, a_mem_we;
    wire [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
    wire [3:0]  a_mem_be;
    wire        b_req_ready, b_rsp_valid, b_rsp_fault, b_mem_req, b_mem_we;
    wire [63:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
    wire [7:0]  b_mem_be;

    lsu_align_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_fault(a_rsp_fault),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata[31:0]), .mem_ack(a_ack)
    );

    lsu_align_unit #(.XLEN(64)) u_dut64 (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(b_ack)
    );

    // Observed view of whichever instance is selected.
    wire        o_req_ready = sel ? b_req_ready : a_req_ready;
    wire        o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    wire        o_rsp_fault = sel ? b_rsp_fault : a_rsp_fault;
    wire [63:0] o_rsp_rdata = sel ? b_rsp_rdata : {32'd0, a_rsp_rdata};
    wire        o_mem_req   = sel ? b_mem_req   : a_mem_req;
    wire        o_mem_we    = sel ? b_mem_we    : a_mem_we;
    wire [63:0] o_mem_addr  = sel ? b_mem_addr  : {32'd0, a_mem_addr};
    wire [7:0]  o_mem_be    = sel ? b_mem_be    : {4'd0, a_mem_be};
    wire [63:0] o_mem_wdata = sel ? b_mem_wdata : {32'd0, a_mem_wdata};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One access: issue it, answer each beat after dly wait cycles, check beats and response.
    task automatic run_access(input string tag, input logic s, input logic st, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wd, input int dly,
                              input logic [63:0] rd0, input logic [63:0] rd1, input int nb,
                              input logic [63:0] ea0, input logic [7:0] eb0, input logic [63:0] ew0,
                              input logic [63:0] ea1, input logic [7:0] eb1, input logic [63:0] ew1,
                              input logic ef, input logic [63:0] er, input int elat);
        int beat;
        int waitc;
        bit done;
        sel = s;
        @(negedge clk);
        check_eq({tag, ".ready"}, 64'(o_req_ready), 64'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        beat  = 0;
        waitc = 0;
        done  = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (o_rsp_valid) begin
                check_eq({tag, ".lat"},   64'(k),           64'(elat));
                check_eq({tag, ".fault"}, 64'(o_rsp_fault), 64'(ef));
                check_eq({tag, ".rdata"}, o_rsp_rdata,      er);
                check_eq({tag, ".beats"}, 64'(beat),        64'(nb));
                done = 1'b1;
            end else if (o_mem_req) begin
                check_eq({tag, ".we"},    64'(o_mem_we),  64'(st));
                check_eq({tag, ".addr"},  o_mem_addr,     (beat == 0) ? ea0 : ea1);
                check_eq({tag, ".be"},    64'(o_mem_be),  64'((beat == 0) ? eb0 : eb1));
                check_eq({tag, ".wdata"}, o_mem_wdata,    (beat == 0) ? ew0 : ew1);
                if (waitc == dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (beat == 0) ? rd0 : rd1;
                    beat++;
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end
        end
        check_eq({tag, ".done"}, 64'(done), 64'd1);
        @(negedge clk);
        check_eq({tag, ".pulse"}, 64'(o_rsp_valid), 64'd0);
        check_eq({tag, ".idle"},  64'(o_req_ready), 64'd1);
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_eq("rst.ready", 64'(o_req_ready), 64'd1);
            check_eq("rst.rsp",   64'(o_rsp_valid), 64'd0);
            check_eq("rst.fault", 64'(o_rsp_fault), 64'd0);
            check_eq("rst.rdata", o_rsp_rdata,      64'd0);
            check_eq("rst.req",   64'(o_mem_req),   64'd0);
            check_eq("rst.we",    64'(o_mem_we),    64'd0);
            check_eq("rst.addr",  o_mem_addr,       64'd0);
            check_eq("rst.be",    64'(o_mem_be),    64'd0);
            check_eq("rst.wdata", o_mem_wdata,      64'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // XLEN = 32: tag, sel, st, f3, addr, wdata, dly, rd0, rd1, nb, ea0, eb0, ew0, ea1, eb1, ew1, fault, rdata, lat
        run_access("lb",  0, 0, 3'b000, 64'h103, 64'h0,        0, 64'h80FF1234, 64'h0, 1, 64'h100, 8'h8, 64'h0,        64'h0, 8'h0, 64'h0, 0, 64'hFFFFFF80, 2);
        run_access("sh",  0, 1, 3'b001, 64'h102, 64'hBEEF,     0, 64'h12345678, 64'h0, 1, 64'h100, 8'hC, 64'hBEEF0000, 64'h0, 8'h0, 64'h0, 0, 64'h0,        2);
        run_access("lhu", 0, 0, 3'b101, 64'h0FE, 64'h0,        3, 64'h87654321, 64'h0, 1, 64'h0FC, 8'hC, 64'h0,        64'h0, 8'h0, 64'h0, 0, 64'h8765,     5);
        run_access("lh",  0, 0, 3'b001, 64'h102, 64'h0,        1, 64'h80015555, 64'h0, 1, 64'h100, 8'hC, 64'h0,        64'h0, 8'h0, 64'h0, 0, 64'hFFFF8001, 3);
        run_access("lbu", 0, 0, 3'b100, 64'h101, 64'h0,        0, 64'h0000F200, 64'h0, 1, 64'h100, 8'h2, 64'h0,        64'h0, 8'h0, 64'h0, 0, 64'hF2,       2);
        run_access("sb",  0, 1, 3'b000, 64'h101, 64'h12345677, 0, 64'h0,        64'h0, 1, 64'h100, 8'h2, 64'h34567700, 64'h0, 8'h0, 64'h0, 0, 64'h0,        2);
        run_access("sw",  0, 1, 3'b010, 64'h200, 64'hDEADBEEF, 0, 64'h0,        64'h0, 1, 64'h200, 8'hF, 64'hDEADBEEF, 64'h0, 8'h0, 64'h0, 0, 64'h0,        2);
        run_access("lw",  0, 0, 3'b010, 64'h204, 64'h0,        0, 64'h89ABCDEF, 64'h0, 1, 64'h204, 8'hF, 64'h0,        64'h0, 8'h0, 64'h0, 0, 64'h89ABCDEF, 2);
        run_access("ld32",0, 0, 3'b011, 64'h100, 64'h0,        0, 64'h0,        64'h0, 0, 64'h0,   8'h0, 64'h0,        64'h0, 8'h0, 64'h0, 1, 64'h0,        1);
        run_access("st4", 0, 1, 3'b100, 64'h100, 64'h55,       0, 64'h0,        64'h0, 0, 64'h0,   8'h0, 64'h0,        64'h0, 8'h0, 64'h0, 1, 64'h0,        1);
        run_access("ld7", 0, 0, 3'b111, 64'h100, 64'h0,        0, 64'h0,        64'h0, 0, 64'h0,   8'h0, 64'h0,        64'h0, 8'h0, 64'h0, 1, 64'h0,        1);
`ifdef LSU_MISALIGN_SPLIT_EN
        run_access("lwx", 0, 0, 3'b010, 64'h1FE, 64'h0,        0, 64'hAABB1111, 64'h2222CCDD, 2, 64'h1FC, 8'hC, 64'h0, 64'h200, 8'h3, 64'h0, 0, 64'hCCDDAABB, 3);
        run_access("lhm", 0, 0, 3'b001, 64'h101, 64'h0,        0, 64'h00ABCD00, 64'h0, 1, 64'h100, 8'h6, 64'h0,        64'h0, 8'h0, 64'h0, 0, 64'hFFFFABCD, 2);
        run_access("shx", 0, 1, 3'b001, 64'h103, 64'hBEEF,     1, 64'h0,        64'h0, 2, 64'h100, 8'h8, 64'hEF000000, 64'h104, 8'h1, 64'hBE, 0, 64'h0, 5);
`else
        run_access("lwx", 0, 0, 3'b010, 64'h1FE, 64'h0,        0, 64'hAABB1111, 64'h2222CCDD, 0, 64'h0, 8'h0, 64'h0, 64'h0, 8'h0, 64'h0, 1, 64'h0, 1);
        run_access("lhm", 0, 0, 3'b001, 64'h101, 64'h0,        0, 64'h00ABCD00, 64'h0, 0, 64'h0,   8'h0, 64'h0,        64'h0, 8'h0, 64'h0, 1, 64'h0,        1);
        run_access("shx", 0, 1, 3'b001, 64'h103, 64'hBEEF,     1, 64'h0,        64'h0, 0, 64'h0,   8'h0, 64'h0,        64'h0, 8'h0, 64'h0, 1, 64'h0,        1);
`endif

        // XLEN = 64
        run_access("ld64", 1, 0, 3'b011, 64'h108, 64'h0, 0, 64'h0123456789ABCDEF, 64'h0, 1, 64'h108, 8'hFF, 64'h0, 64'h0, 8'h0, 64'h0, 0, 64'h0123456789ABCDEF, 2);
        run_access("lwu64",1, 0, 3'b110, 64'h10C, 64'h0, 0, 64'h8000000100000000, 64'h0, 1, 64'h108, 8'hF0, 64'h0, 64'h0, 8'h0, 64'h0, 0, 64'h0000000080000001, 2);
        run_access("lw64", 1, 0, 3'b010, 64'h10C, 64'h0, 0, 64'h8000000100000000, 64'h0, 1, 64'h108, 8'hF0, 64'h0, 64'h0, 8'h0, 64'h0, 0, 64'hFFFFFFFF80000001, 2);
        run_access("sd64", 1, 1, 3'b011, 64'h110, 64'h1122334455667788, 0, 64'h0, 64'h0, 1, 64'h110, 8'hFF, 64'h1122334455667788, 64'h0, 8'h0, 64'h0, 0, 64'h0, 2);

        // Reset while a beat is outstanding, then a stray late acknowledge.
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 64'h103;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("rb.req_before", 64'(o_mem_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rb.req",   64'(o_mem_req),   64'd0);
        check_eq("rb.ready", 64'(o_req_ready), 64'd1);
        check_eq("rb.rsp",   64'(o_rsp_valid), 64'd0);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 64'h80FF1234;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("rb.late_rsp", 64'(o_rsp_valid), 64'd0);
            check_eq("rb.late_req", 64'(o_mem_req),   64'd0);
            @(negedge clk);
        end
        check_eq("rb.ready_end", 64'(o_req_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Parametrised load/store alignment unit between the multicycle core's memory stage and a word-wide data memory port.
- Generates byte enables and lane-shifted store data from the byte address and funct3.
- Extracts, shifts and sign- or zero-extends load data.
- Sequences bus beats through a request/response handshake. Optionally splits misaligned accesses into two beats.

Parameters:
- XLEN, 32, datapath width; 32 or 64. At 64, LD/SD/LWU are legal.
- NB, XLEN/8, byte lanes per memory word (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents an access
- req_ready  out  1  unit can accept an access (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  XLEN  extended load data (0 for stores and faults)
- rsp_fault  out  1  qualifies rsp_valid: illegal funct3, or misaligned access without the split feature
- mem_req  out  1  beat request, held until mem_ack
- mem_we  out  1  write beat
- mem_addr  out  XLEN  word-aligned beat address (low log2(NB) bits = 0)
- mem_be  out  NB  byte enables
- mem_wdata  out  XLEN  lane-positioned store data
- mem_rdata  in  XLEN  read word, valid with mem_ack
- mem_ack  in  1  beat done; may arrive the same cycle mem_req rises, or any later cycle

Behaviour:
- Reset: all outputs 0 except req_ready = 1. FSM goes to IDLE; all registers clear. Reset overrides any in-flight beat; a later mem_ack is ignored.
- FSM: IDLE, BEAT0, BEAT1, RESP.
- IDLE: on req_valid, capture all req_* fields. Decode size: 1, 2, 4 or 8 bytes; 8 only for funct3 011 when XLEN=64.
  - Legal load funct3: 000, 001, 010, 100, 101, plus 011 and 110 when XLEN=64.
  - Legal store funct3: 000, 001, 010, plus 011 when XLEN=64.
  - Illegal funct3: go to RESP with fault; no memory beat.
- Alignment: off = addr mod NB; misaligned if addr mod size != 0. Crossing if off + size > NB.
- BEAT0:
  - mem_addr = addr with low bits cleared.
  - mem_be = ((1<<size)-1) << off, truncated to NB bits.
  - mem_wdata = wdata << 8*off.
  - On mem_ack: latch mem_rdata >> 8*off into the low bytes of the assembly register. Go to BEAT1 if crossing, else RESP.
- BEAT1:
  - mem_addr = beat0 address + NB.
  - mem_be = low (off + size - NB) lanes set.
  - mem_wdata = wdata >> 8*(NB-off).
  - On mem_ack: place mem_rdata bytes above the beat0 bytes.
- RESP: rsp_valid = 1 for one cycle, then return to IDLE. req_ready is 0 in every state but IDLE.
- Load extension, applied to the assembled bytes:
  - 000 / 001 / 010: sign-extend from bit 7 / 15 / 31.
  - 100 / 101 / 110: zero-extend.
  - 011: full width.
- Latency, aligned: accept -> rsp_valid = 2 cycles when mem_ack is immediate. Crossing: 3 cycles. Each wait cycle on mem_ack adds 1.
- mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and stable while mem_req is high and mem_ack is low.
- req_valid is ignored outside IDLE. Back-to-back accesses are possible: IDLE accepts in the cycle after RESP.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned non-crossing accesses execute in one beat. Crossing accesses execute as two beats (BEAT0 then BEAT1).
- Undefined: BEAT1 is not built. Any misaligned access goes IDLE -> RESP with rsp_fault = 1, rsp_rdata = 0 and no mem_req.

Test Plan:
- XLEN=32, load LB, addr 0x103, mem_rdata 0x80FF_1234, immediate ack -> mem_addr 0x100, mem_be 1000, rsp_rdata 0xFFFF_FF80 two cycles after accept.
- Store SH, addr 0x102, wdata 0x0000_BEEF -> mem_we 1, mem_be 1100, mem_wdata 0xBEEF_0000, rsp_fault 0.
- Load LHU, addr 0x0FE, mem_ack delayed 3 cycles -> mem_req held with stable outputs; rsp_rdata is zero-extended upper half; latency = 5.
- Split enabled: LW at addr 0x1FE, beat0 rdata 0xAABB_xxxx, beat1 rdata 0xxxxx_CCDD -> beats at 0x1FC (be 1100) then 0x200 (be 0011); rsp_rdata 0xCCDD_AABB. Split disabled: same access gives rsp_fault 1 and no mem_req.
- Load funct3 011 with XLEN=32 -> rsp_fault 1 and no mem_req. Same with XLEN=64 (LD), aligned -> mem_be 0xFF and full 64-bit data returned.
- Reset asserted during BEAT0 with mem_req high -> next cycle mem_req 0 and req_ready 1. A late mem_ack produces no rsp_valid.
